// File: rtl/fifo_axis_pkg.sv
// Shared types and constants for the FWFT-FIFO to AXI-Stream reader.
package fifo_axis_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_e;

    localparam int OCC_W              = 2;
    localparam int DATA_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry in-order output buffer (head + skid) driving an AXI-Stream master port.
module axis_skid_buf
    import fifo_axis_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [OCC_W-1:0]      occ
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  hs;

    assign m_tvalid = (occ_q != '0);
    assign m_tdata  = head_q;
    assign occ      = occ_q;
    assign hs       = m_tvalid && m_tready;

    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        occ_d  = occ_q;
        case (occ_q)
            OCC_W'(0): begin
                if (push) begin
                    head_d = data_in;
                    occ_d  = OCC_W'(1);
                end
            end
            OCC_W'(1): begin
                if (hs && push) begin
                    head_d = data_in;
                end else if (hs) begin
                    occ_d = OCC_W'(0);
                end else if (push) begin
                    skid_d = data_in;
                    occ_d  = OCC_W'(2);
                end
            end
            default: begin
                // Full: the older skid word is promoted so order is preserved.
                if (hs) begin
                    head_d = skid_q;
                    if (push) begin
                        skid_d = data_in;
                    end else begin
                        occ_d = OCC_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            skid_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            skid_q <= skid_d;
            occ_q  <= occ_d;
        end
    end

endmodule

// File: rtl/fifo_axis_reader.sv
// Drains an FWFT FIFO into an AXI-Stream master with framed TLAST generation.
module fifo_axis_reader
    import fifo_axis_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  wr_clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [LEN_WIDTH-1:0]  cfg_frame_len,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  frame_done,
    output logic [LEN_WIDTH-1:0]  beat_cnt
);

    logic [OCC_W-1:0]     occ;
    logic                 hs;
    logic                 last_beat;
    logic [LEN_WIDTH-1:0] cfg_len_safe;

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [LEN_WIDTH-1:0] frame_len_q, frame_len_d;
    logic                 frame_done_q, frame_done_d;

    // Gated by rst_n so nothing is popped (and lost) while reset is held.
    assign fifo_rd_en = rst_n && enable && !fifo_empty && (occ < OCC_W'(2));

    axis_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk      (wr_clk),
        .rst_n    (rst_n),
        .push     (fifo_rd_en),
        .data_in  (fifo_dout),
        .m_tdata  (m_axis_tdata),
        .m_tvalid (m_axis_tvalid),
        .m_tready (m_axis_tready),
        .occ      (occ)
    );

    assign hs           = m_axis_tvalid && m_axis_tready;
    assign last_beat    = (beat_cnt_q == frame_len_q - LEN_WIDTH'(1));
    assign m_axis_tlast = m_axis_tvalid && last_beat;
    assign frame_done   = frame_done_q;
    assign beat_cnt     = beat_cnt_q;
    assign cfg_len_safe = (cfg_frame_len == '0) ? LEN_WIDTH'(1) : cfg_frame_len;

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        frame_len_d  = frame_len_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                beat_cnt_d  = '0;
                frame_len_d = cfg_len_safe;
                if (hs) begin
                    if (last_beat) begin
                        frame_done_d = 1'b1;
                    end else begin
                        state_d     = FRAME;
                        beat_cnt_d  = LEN_WIDTH'(1);
                        frame_len_d = frame_len_q;
                    end
                end
            end
            default: begin
                if (hs) begin
                    if (last_beat) begin
                        // Reload on exit so a back-to-back first beat already sees the new length.
                        state_d      = IDLE;
                        beat_cnt_d   = '0;
                        frame_len_d  = cfg_len_safe;
                        frame_done_d = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            frame_len_q  <= LEN_WIDTH'(1);
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            frame_len_q  <= frame_len_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule
